branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
//  Sequences branch resolution for the 5-stage pipeline.
//  Samples Branch/Zero from the EX/MEM register and decides taken when both are 1.
//  Drives the registered PCSrc redirect and the target PC to the fetch-stage PC mux.
//  Sequences the multi-cycle flush of the wrong-path IF/ID, ID/EX and EX/MEM contents, honouring pipeline stalls.
// PARAMETERS
//  ADDR_W        32  width of PC / branch target
//  FLUSH_CYCLES   2  cycles of FLUSH state after REDIRECT; legal 1..7
//  CNT_W         16  width of statistics counters (BRANCH_STATS_EN only)
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       asynchronous, active-high reset
//  Branch         in   1       EX/MEM branch control bit
//  Zero           in   1       EX/MEM ALU zero flag
//  branch_target  in   ADDR_W  EX/MEM computed branch target
//  stall          in   1       pipeline hold (hazard unit / memory wait)
//  PCSrc          out  1       select branch target at PC mux
//  pc_target      out  ADDR_W  latched redirect target
//  flush_if_id    out  1       bubble IF/ID
//  flush_id_ex    out  1       bubble ID/EX
//  flush_ex_mem   out  1       bubble EX/MEM (REDIRECT cycle only)
//  busy           out  1       high in any state except IDLE
//  taken_cnt      out  CNT_W   taken-branch count
//  not_taken_cnt  out  CNT_W   not-taken-branch count
// BEHAVIOUR
//  States: IDLE, REDIRECT, FLUSH. All outputs are decoded from registered state and are glitch-free.
//  Reset (async, rst=1): state=IDLE, tgt_q=0, cnt=0, PCSrc=0, pc_target=0, all flush=0, busy=0, counters=0.
//  IDLE:
//   - taken = Branch & Zero & ~stall.
//   - On a taken edge: latch tgt_q <= branch_target, load cnt <= FLUSH_CYCLES-1, go to REDIRECT.
//   - Branch=1 with stall=1: not sampled; it is re-evaluated in the next cycle.
//  REDIRECT:
//   - PCSrc=1, pc_target=tgt_q, flush_if_id=flush_id_ex=flush_ex_mem=1.
//   - stall=1: hold REDIRECT with all outputs unchanged.
//   - stall=0: go to FLUSH.
//  FLUSH:
//   - PCSrc=0, flush_if_id=flush_id_ex=1, flush_ex_mem=0.
//   - stall=0: if cnt==0 go to IDLE, else cnt-1. stall=1: cnt held.
//  Latency: taken sampled at edge N -> PCSrc high in cycle N+1.
//   - Redirect to IDLE takes 1+FLUSH_CYCLES unstalled cycles.
//  Branch, Zero and branch_target are ignored in REDIRECT and FLUSH: the flush kills those wrong-path instructions.
//  pc_target holds tgt_q in every state. It is meaningful only while PCSrc=1.
//  busy = (state != IDLE). A new taken branch is accepted only in IDLE, never in the same cycle as the IDLE return.
//  Reset asserted mid-REDIRECT/FLUSH: immediate return to IDLE, outputs at reset values, no redirect completes.
//  Illegal state encoding: next state IDLE.
// CONFIGURATION
//  BRANCH_STATS_EN defined:
//   - In IDLE with stall=0: Branch&Zero increments taken_cnt; Branch&~Zero increments not_taken_cnt.
//   - Both counters saturate at all-ones and reset to 0.
//  BRANCH_STATS_EN undefined: no counter flops; taken_cnt and not_taken_cnt are tied to 0.
// TESTING
//  T1: reset; Branch=1,Zero=1,target=0x0000_0040 at edge 1
//      -> PCSrc=1, pc_target=0x40 and all three flushes high in cycle 2;
//      -> flush_if_id/id_ex high in cycles 3-4; busy low in cycle 5 (FLUSH_CYCLES=2).
//  T2: Branch=1,Zero=0 in IDLE -> PCSrc stays 0, busy stays 0, no flush;
//      -> not_taken_cnt=1 with BRANCH_STATS_EN.
//  T3: taken branch, then stall=1 for 3 cycles in REDIRECT
//      -> PCSrc=1 for 4 cycles, pc_target stable; FLUSH then lasts 2 cycles.
//  T4: Branch=1,Zero=1,target=0x80 every cycle during REDIRECT/FLUSH
//      -> pc_target stays at the first target (0x40);
//      -> second branch accepted only on the first IDLE edge.
//  T5: rst pulsed asynchronously mid-FLUSH
//      -> all outputs 0 before the next clock edge; state IDLE.
//  T6 (BRANCH_STATS_EN, CNT_W=4): 17 taken branches -> taken_cnt saturates at 0xF.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer: IDLE -> REDIRECT -> FLUSH, with stall-aware flush timing.
// Optional taken/not-taken statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_redirect_ctrl #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Branch,
    input  logic              Zero,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              stall,
    output logic              PCSrc,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic              busy,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  not_taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_REDIRECT = 2'b01,
        S_FLUSH    = 2'b10
    } state_t;

    localparam logic [2:0] LP_CNT_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_tgt;
    logic [ADDR_W-1:0] w_tgt_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic              w_taken;

    assign w_taken = Branch & Zero & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tgt   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tgt   <= w_tgt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs decode only r_state/r_tgt, so they never follow the EX/MEM inputs combinationally.
    always_comb begin
        w_state_nxt  = r_state;
        w_tgt_nxt    = r_tgt;
        w_cnt_nxt    = r_cnt;
        PCSrc        = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        busy         = 1'b1;
        pc_target    = r_tgt;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_taken) begin
                    w_tgt_nxt   = branch_target;
                    w_cnt_nxt   = LP_CNT_LOAD;
                    w_state_nxt = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                PCSrc        = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
                if (!stall) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                if (!stall) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef BRANCH_STATS_EN
    logic              w_sample;
    logic [CNT_W-1:0]  r_taken_cnt;
    logic [CNT_W-1:0]  r_not_taken_cnt;

    assign w_sample = (r_state == S_IDLE) & ~stall & Branch;

    // Both counters saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_taken_cnt     <= '0;
            r_not_taken_cnt <= '0;
        end else begin
            if (w_sample && Zero && (r_taken_cnt != '1)) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
            if (w_sample && !Zero && (r_not_taken_cnt != '1)) begin
                r_not_taken_cnt <= r_not_taken_cnt + CNT_W'(1);
            end
        end
    end

    assign taken_cnt     = r_taken_cnt;
    assign not_taken_cnt = r_not_taken_cnt;
`else
    assign taken_cnt     = '0;
    assign not_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed, table-driven bench for branch_redirect_ctrl (FLUSH_CYCLES=2, CNT_W=4).
module tb_branch_redirect_ctrl;

`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        Branch, Zero, stall;
    logic [31:0] branch_target;
    logic        PCSrc, flush_if_id, flush_id_ex, flush_ex_mem, busy;
    logic [31:0] pc_target;
    logic [3:0]  taken_cnt, not_taken_cnt;

    int n_vec = 0;
    int n_err = 0;

    branch_redirect_ctrl #(
        .ADDR_W       (32),
        .FLUSH_CYCLES (2),
        .CNT_W        (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Branch        (Branch),
        .Zero          (Zero),
        .branch_target (branch_target),
        .stall         (stall),
        .PCSrc         (PCSrc),
        .pc_target     (pc_target),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .flush_ex_mem  (flush_ex_mem),
        .busy          (busy),
        .taken_cnt     (taken_cnt),
        .not_taken_cnt (not_taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        br, z, st;
        logic [31:0] tgt;
        logic        pcsrc;
        logic [31:0] ptgt;
        logic        fif, fie, fem, busy;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic br, logic z, logic st, logic [31:0] tgt,
                                logic pcsrc, logic [31:0] ptgt,
                                logic fif, logic fie, logic fem, logic bsy);
        vec_t v;
        v.br = br; v.z = z; v.st = st; v.tgt = tgt;
        v.pcsrc = pcsrc; v.ptgt = ptgt;
        v.fif = fif; v.fie = fie; v.fem = fem; v.busy = bsy;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_outs(int idx, logic pcsrc, logic [31:0] ptgt, logic fif, logic fie,
                            logic fem, logic bsy, logic [3:0] tc, logic [3:0] ntc);
        chk("PCSrc",        idx, 32'(PCSrc),         32'(pcsrc));
        chk("pc_target",    idx, pc_target,          ptgt);
        chk("flush_if_id",  idx, 32'(flush_if_id),   32'(fif));
        chk("flush_id_ex",  idx, 32'(flush_id_ex),   32'(fie));
        chk("flush_ex_mem", idx, 32'(flush_ex_mem),  32'(fem));
        chk("busy",         idx, 32'(busy),          32'(bsy));
        chk("taken_cnt",    idx, 32'(taken_cnt),     32'(tc));
        chk("not_taken_cnt",idx, 32'(not_taken_cnt), 32'(ntc));
    endtask

    task automatic drive(logic br, logic z, logic st, logic [31:0] tgt);
        Branch = br; Zero = z; stall = st; branch_target = tgt;
    endtask

    initial begin
        logic       idle;
        logic [3:0] exp_tc, exp_ntc;

        //             br  z   st  target      PCSrc pc_target   fif fie fem busy
        vecs[0]  = mk(1, 1, 0, 32'h40,  1, 32'h40,  1, 1, 1, 1); // T1 taken
        vecs[1]  = mk(0, 0, 0, 32'h0,   0, 32'h40,  1, 1, 0, 1);
        vecs[2]  = mk(0, 0, 0, 32'h0,   0, 32'h40,  1, 1, 0, 1);
        vecs[3]  = mk(0, 0, 0, 32'h0,   0, 32'h40,  0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 32'h77,  0, 32'h40,  0, 0, 0, 0); // T2 not taken
        vecs[5]  = mk(1, 0, 0, 32'h78,  0, 32'h40,  0, 0, 0, 0);
        vecs[6]  = mk(1, 1, 1, 32'h99,  0, 32'h40,  0, 0, 0, 0); // stalled: not sampled
        vecs[7]  = mk(1, 1, 0, 32'h200, 1, 32'h200, 1, 1, 1, 1); // T3 taken
        vecs[8]  = mk(1, 1, 1, 32'h80,  1, 32'h200, 1, 1, 1, 1); // REDIRECT held
        vecs[9]  = mk(1, 1, 1, 32'h80,  1, 32'h200, 1, 1, 1, 1);
        vecs[10] = mk(1, 1, 1, 32'h80,  1, 32'h200, 1, 1, 1, 1);
        vecs[11] = mk(1, 1, 0, 32'h80,  0, 32'h200, 1, 1, 0, 1);
        vecs[12] = mk(1, 1, 1, 32'h80,  0, 32'h200, 1, 1, 0, 1); // FLUSH held
        vecs[13] = mk(1, 1, 0, 32'h80,  0, 32'h200, 1, 1, 0, 1);
        vecs[14] = mk(1, 1, 0, 32'h80,  0, 32'h200, 0, 0, 0, 0); // IDLE return, no accept
        vecs[15] = mk(1, 1, 0, 32'h80,  1, 32'h80,  1, 1, 1, 1); // accepted on first IDLE edge
        vecs[16] = mk(0, 0, 0, 32'h0,   0, 32'h80,  1, 1, 0, 1);
        vecs[17] = mk(0, 0, 0, 32'h0,   0, 32'h80,  1, 1, 0, 1);
        vecs[18] = mk(0, 0, 0, 32'h0,   0, 32'h80,  0, 0, 0, 0);

        rst = 1'b1;
        drive(0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk_outs(-1, 0, 32'h0, 0, 0, 0, 0, 4'h0, 4'h0);
        rst = 1'b0;

        idle = 1'b1; exp_tc = '0; exp_ntc = '0;
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].br, vecs[i].z, vecs[i].st, vecs[i].tgt);
            if (STATS && idle && !vecs[i].st && vecs[i].br) begin
                if (vecs[i].z) begin
                    if (exp_tc != 4'hF) exp_tc = exp_tc + 4'd1;
                end else begin
                    if (exp_ntc != 4'hF) exp_ntc = exp_ntc + 4'd1;
                end
            end
            @(posedge clk);
            #1;
            chk_outs(i, vecs[i].pcsrc, vecs[i].ptgt, vecs[i].fif, vecs[i].fie,
                     vecs[i].fem, vecs[i].busy, exp_tc, exp_ntc);
            idle = ~vecs[i].busy;
        end

        // T5: asynchronous reset in the middle of FLUSH
        drive(1, 1, 0, 32'h40);
        @(posedge clk); #1;
        drive(0, 0, 0, 32'h0);
        @(posedge clk); #1;
        chk("t5_in_flush", 0, 32'(flush_if_id), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_outs(100, 0, 32'h0, 0, 0, 0, 0, 4'h0, 4'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_outs(101, 0, 32'h0, 0, 0, 0, 0, 4'h0, 4'h0);

        // T6: 17 taken branches, each followed by the full redirect/flush sequence
        for (int k = 0; k < 17; k++) begin
            drive(1, 1, 0, 32'(k * 4));
            @(posedge clk); #1;
            drive(0, 0, 0, 32'h0);
            repeat (3) @(posedge clk);
            #1;
        end
        chk_outs(200, 0, 32'(16 * 4), 0, 0, 0, 0, STATS ? 4'hF : 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
